// File: rtl/pimt_pkg.sv
// Shared constants and types for the pimt scaled-product stage.
`timescale 1ns/1ps
package pimt_pkg;

  localparam int unsigned FP64_W        = 64;
  localparam int unsigned FP64_EXP_MSB  = 62;
  localparam int unsigned FP64_EXP_LSB  = 52;
  localparam logic [10:0] FP64_EXP_ONES = 11'h7FF;
  localparam logic [63:0] FP64_SCALE_64 = 64'h4050000000000000;

  typedef enum logic {DRAIN, RUN} state_e;

  // True when the FP64 exponent field is all ones (Inf or NaN).
  function automatic logic exp_all_ones(input logic [FP64_W-1:0] d);
    return d[FP64_EXP_MSB:FP64_EXP_LSB] == FP64_EXP_ONES;
  endfunction

endpackage

// File: rtl/floating_point_0.sv
// FP64 multiplier with fixed latency LAT, no reset, no backpressure.
// Round-to-nearest-even; subnormal inputs and results are flushed to zero.
`timescale 1ns/1ps
module floating_point_0 #(
  parameter int unsigned LAT = 8
) (
  input  logic        aclk,
  input  logic        s_axis_a_tvalid,
  input  logic [63:0] s_axis_a_tdata,
  input  logic        s_axis_b_tvalid,
  input  logic [63:0] s_axis_b_tdata,
  output logic        m_axis_result_tvalid,
  output logic [63:0] m_axis_result_tdata
);

  logic         sign, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic         guard, sticky, round_up;
  logic [10:0]  ea, eb;
  logic [51:0]  fa, fb, mant;
  logic [105:0] prod;
  logic [52:0]  mant_r;
  logic [13:0]  e_sum, e_adj;
  logic [63:0]  res;
  logic [LAT-1:0] v_pipe;
  logic [63:0]    d_pipe [LAT];

  // Combinational IEEE-754 double product.
  always_comb begin
    sign   = s_axis_a_tdata[63] ^ s_axis_b_tdata[63];
    ea     = s_axis_a_tdata[62:52];
    eb     = s_axis_b_tdata[62:52];
    fa     = s_axis_a_tdata[51:0];
    fb     = s_axis_b_tdata[51:0];
    a_nan  = (ea == 11'h7FF) && (fa != '0);
    b_nan  = (eb == 11'h7FF) && (fb != '0);
    a_inf  = (ea == 11'h7FF) && (fa == '0);
    b_inf  = (eb == 11'h7FF) && (fb == '0);
    a_zero = (ea == 11'h000);
    b_zero = (eb == 11'h000);
    prod   = 106'({1'b1, fa}) * 106'({1'b1, fb});
    if (prod[105]) begin
      mant   = prod[104:53];
      guard  = prod[52];
      sticky = |prod[51:0];
    end else begin
      mant   = prod[103:52];
      guard  = prod[51];
      sticky = |prod[50:0];
    end
    round_up = guard & (sticky | mant[0]);
    mant_r   = 53'(mant) + 53'(round_up);
    e_sum    = 14'(ea) + 14'(eb) + 14'(prod[105]);
    e_adj    = e_sum + 14'(mant_r[52]);
    res      = '0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      res = 64'h7FF8000000000000;
    else if (a_inf || b_inf)
      res = {sign, 11'h7FF, 52'h0};
    else if (a_zero || b_zero)
      res = {sign, 63'h0};
    else if (e_adj >= 14'd3070)
      res = {sign, 11'h7FF, 52'h0};
    else if (e_adj <= 14'd1023)
      res = {sign, 63'h0};
    else
      res = {sign, 11'(e_adj - 14'd1023), mant_r[51:0]};
  end

  // Fixed-latency result pipeline.
  always_ff @(posedge aclk) begin
    v_pipe    <= {v_pipe[LAT-2:0], s_axis_a_tvalid & s_axis_b_tvalid};
    d_pipe[0] <= res;
    for (int i = 1; i < LAT; i++) d_pipe[i] <= d_pipe[i-1];
  end

  assign m_axis_result_tvalid = v_pipe[LAT-1];
  assign m_axis_result_tdata  = d_pipe[LAT-1];

endmodule

// File: rtl/pimt_out_fifo.sv
// Synchronous result FIFO with occupancy count and sticky overflow flag.
`timescale 1ns/1ps
module pimt_out_fifo #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 72
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_rd, do_wr, full;

  assign full  = (cnt == CW'(DEPTH));
  assign do_rd = rd_en && (cnt != '0);
  // A write at full is legal only when a read frees the slot in the same cycle.
  assign do_wr = wr_en && (!full || do_rd);

  // Storage array; contents are qualified by the count so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      if (do_wr && !do_rd)      cnt <= cnt + CW'(1);
      else if (do_rd && !do_wr) cnt <= cnt - CW'(1);
      if (wr_en && !do_wr) ovf <= 1'b1;
    end
  end

  assign rd_valid = (cnt != '0);
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
  assign count    = cnt;

endmodule

// File: rtl/pimt_scaled_mul.sv
// Streaming FP64 r = a * b * SCALE with tag tracking, output FIFO and credit admission.
// Optional feature macro: PIMT_EXC_DETECT_EN (flags Inf/NaN results on out_exc).
`timescale 1ns/1ps
module pimt_scaled_mul
  import pimt_pkg::*;
#(
  parameter logic [63:0] SCALE      = FP64_SCALE_64,
  parameter int unsigned MUL_LAT    = 8,
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned TAG_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_a,
  input  logic [63:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_exc,
  output logic             busy,
  output logic             err_ovf
);

  localparam int unsigned DL_LEN  = 2 * MUL_LAT;
  localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SW      = CW + 1;
  localparam int unsigned DRAIN_W = $clog2(DL_LEN) + 1;
`ifdef PIMT_EXC_DETECT_EN
  localparam int unsigned FW = FP64_W + TAG_W + 1;
`else
  localparam int unsigned FW = FP64_W + TAG_W;
`endif

  state_e              state;
  logic [DRAIN_W-1:0]  drain_cnt;
  logic [CW-1:0]       inflight, fifo_count;
  logic [SW-1:0]       credit_used;
  logic                accept, res_valid;
  logic                m1_valid, m2_valid;
  logic [63:0]         m1_data, m2_data;
  logic [DL_LEN-1:0]   dl_vld;
  logic [TAG_W-1:0]    dl_tag [DL_LEN];
  logic [FW-1:0]       wr_data, rd_data;

  assign credit_used = SW'(inflight) + SW'(fifo_count);
  assign in_ready    = (state == RUN) && (credit_used < SW'(FIFO_DEPTH));
  assign accept      = in_valid && in_ready;
  // Multipliers carry no reset; anything emerging during DRAIN is stale.
  assign res_valid   = (state == RUN) && m2_valid;

  // Hold DRAIN for 2*MUL_LAT cycles after reset so both multiplier pipes empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= DRAIN;
      drain_cnt <= '0;
    end else begin
      case (state)
        DRAIN: begin
          if (drain_cnt == DRAIN_W'(DL_LEN - 1)) state <= RUN;
          else                                     drain_cnt <= drain_cnt + DRAIN_W'(1);
        end
        RUN:     state <= RUN;
        default: state <= DRAIN;
      endcase
    end
  end

  // Pairs inside the multipliers, counted against FIFO space for admission.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({accept, res_valid})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Tag and valid delay line matched to the two multiplier latencies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_vld <= '0;
      for (int i = 0; i < DL_LEN; i++) dl_tag[i] <= '0;
    end else begin
      dl_vld    <= {dl_vld[DL_LEN-2:0], accept};
      dl_tag[0] <= in_tag;
      for (int i = 1; i < DL_LEN; i++) dl_tag[i] <= dl_tag[i-1];
    end
  end

  // Multiplier outputs and the tag line must agree once running.
  assert property (@(posedge clk) disable iff (!rst_n)
                   (state == RUN) |-> (m2_valid == dl_vld[DL_LEN-1]));

  floating_point_0 #(.LAT(MUL_LAT)) u_mul_ab (
    .aclk                 (clk),
    .s_axis_a_tvalid      (accept),
    .s_axis_a_tdata       (in_a),
    .s_axis_b_tvalid      (accept),
    .s_axis_b_tdata       (in_b),
    .m_axis_result_tvalid (m1_valid),
    .m_axis_result_tdata  (m1_data)
  );

  floating_point_0 #(.LAT(MUL_LAT)) u_mul_scale (
    .aclk                 (clk),
    .s_axis_a_tvalid      (m1_valid),
    .s_axis_a_tdata       (m1_data),
    .s_axis_b_tvalid      (m1_valid),
    .s_axis_b_tdata       (SCALE),
    .m_axis_result_tvalid (m2_valid),
    .m_axis_result_tdata  (m2_data)
  );

`ifdef PIMT_EXC_DETECT_EN
  assign wr_data = {exp_all_ones(m2_data), dl_tag[DL_LEN-1], m2_data};
  assign out_exc = rd_data[FW-1];
`else
  assign wr_data = {dl_tag[DL_LEN-1], m2_data};
  assign out_exc = 1'b0;
`endif

  pimt_out_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(FW)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (res_valid),
    .wr_data  (wr_data),
    .rd_en    (out_ready),
    .rd_valid (out_valid),
    .rd_data  (rd_data),
    .count    (fifo_count),
    .ovf      (err_ovf)
  );

  assign out_data = rd_data[FP64_W-1:0];
  assign out_tag  = rd_data[FP64_W +: TAG_W];
  assign busy     = (inflight != '0) || out_valid;

endmodule
